// File: rtl/ioctl_dn_pacer.sv
// ioctl_dn_pacer: buffers host download bytes in a small FIFO and replays
// them onto the dn_* load port at the rate of a clock enable. ioctl_wait
// throttles the host and the block reports session busy/done/count/overflow.
module ioctl_dn_pacer #(
    parameter int DEPTH      = 8,
    parameter int AW         = 17,
    parameter int HIGH_WATER = 6
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [7:0]    ioctl_index,
    output logic          ioctl_wait,
    output logic [AW-1:0] dn_addr,
    output logic [7:0]    dn_data,
    output logic [7:0]    dn_index,
    output logic          dn_wr,
    output logic          dn_busy,
    output logic          dn_done,
    output logic [24:0]   dn_count,
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 16;
    localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] OCC_HIGH = (PW+1)'(HIGH_WATER);
    localparam logic [24:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_occ;

    // Registered outputs
    state_t        r_state;
    logic          r_wait;
    logic          r_dn_wr;
    logic [AW-1:0] r_dn_addr;
    logic [7:0]    r_dn_data;
    logic [7:0]    r_dn_index;
    logic          r_dn_done;
    logic [24:0]   r_dn_count;
    logic          r_overflow;

    // Per-edge decisions, all based on pre-edge occupancy
    logic          w_req;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_start;
    logic [PW:0]   w_occ_next;

    assign w_req      = ioctl_wr & ioctl_download;
    // A full FIFO drops the byte even if a pop frees a slot on the same edge.
    assign w_push     = w_req & (r_occ < OCC_FULL);
    assign w_drop     = w_req & (r_occ >= OCC_FULL);
    assign w_pop      = ce & (r_occ != '0);
    assign w_start    = (r_state == ST_IDLE) & ioctl_download;
    assign w_occ_next = r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);

    // Upper address bits beyond AW are deliberately discarded.
    generate
        if (AW < 25) begin : g_addr_drop
            logic w_addr_unused;
            assign w_addr_unused = ^ioctl_addr[24:AW];
        end
    endgenerate

    // Entry storage: plain array so it maps onto distributed/block RAM.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ioctl_addr[AW-1:0], ioctl_dout, ioctl_index};
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ <= w_occ_next;
        end
    end

    // Drain stage: head entry is registered onto dn_* with a one-cycle strobe.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dn_wr    <= 1'b0;
            r_dn_addr  <= '0;
            r_dn_data  <= '0;
            r_dn_index <= '0;
        end else begin
            r_dn_wr <= w_pop;
            if (w_pop) begin
                {r_dn_addr, r_dn_data, r_dn_index} <= r_mem[r_rd_ptr];
            end
        end
    end

    // Back-pressure follows post-edge occupancy so the host sees it one cycle early.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= 1'b0;
        end else begin
            r_wait <= (w_occ_next >= OCC_HIGH);
        end
    end

    // Session state machine with its done pulse, byte counter and overflow flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_dn_done  <= 1'b0;
            r_dn_count <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_dn_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ioctl_download) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!ioctl_download) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Re-raising download merges into the running session.
                    if (ioctl_download) begin
                        r_state <= ST_ACTIVE;
                    end else if ((r_occ == '0) && !r_dn_wr) begin
                        r_state   <= ST_DONE;
                        r_dn_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A new session restarts the counters; a pop on that edge already counts.
            if (w_start) begin
                r_dn_count <= w_pop ? 25'd1 : 25'd0;
                r_overflow <= w_drop;
            end else begin
                if (w_pop && (r_dn_count != CNT_MAX)) begin
                    r_dn_count <= r_dn_count + 25'd1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign ioctl_wait = r_wait;
    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign dn_index   = r_dn_index;
    assign dn_wr      = r_dn_wr;
    assign dn_busy    = (r_state != ST_IDLE);
    assign dn_done    = r_dn_done;
    assign dn_count   = r_dn_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ioctl_dn_pacer.sv
// tb_ioctl_dn_pacer: scenario tasks driving ioctl_dn_pacer, each checked
// against a queue-based reference model of the download pacer.
module tb_ioctl_dn_pacer;

    localparam int DEPTH = 8;
    localparam int AW    = 17;
    localparam int HW    = 6;
    localparam int VW    = 5 + AW + 16 + 25;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          ce;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          ioctl_wait;
    logic [AW-1:0] dn_addr;
    logic [7:0]    dn_data;
    logic [7:0]    dn_index;
    logic          dn_wr;
    logic          dn_busy;
    logic          dn_done;
    logic [24:0]   dn_count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    ioctl_dn_pacer #(.DEPTH(DEPTH), .AW(AW), .HIGH_WATER(HW)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ce             (ce),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_index       (dn_index),
        .dn_wr          (dn_wr),
        .dn_busy        (dn_busy),
        .dn_done        (dn_done),
        .dn_count       (dn_count),
        .overflow       (overflow)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    i;
    } ent_t;

    ent_t          q[$];
    logic          m_wait, m_wr, m_done, m_ovf;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data, m_idx;
    logic [24:0]   m_count;
    int            m_phase;   // 0 idle, 1 downloading, 2 flushing, 3 done

    task automatic model_reset();
        q.delete();
        m_wait = 0; m_wr = 0; m_done = 0; m_ovf = 0;
        m_addr = '0; m_data = '0; m_idx = '0; m_count = '0; m_phase = 0;
    endtask

    task automatic model_edge();
        int   pre_n;
        int   np;
        logic pop, push, drop, start;
        ent_t h;
        pre_n = q.size();
        pop   = ce && (pre_n > 0);
        push  = ioctl_wr && ioctl_download && (pre_n < DEPTH);
        drop  = ioctl_wr && ioctl_download && (pre_n >= DEPTH);
        start = (m_phase == 0) && ioctl_download;
        np = m_phase;
        if (m_phase == 0 && ioctl_download) np = 1;
        else if (m_phase == 1 && !ioctl_download) np = 2;
        else if (m_phase == 2 && ioctl_download) np = 1;
        else if (m_phase == 2 && pre_n == 0 && !m_wr) np = 3;
        else if (m_phase == 3) np = 0;
        if (pop) begin
            h = q.pop_front();
            m_addr = h.a; m_data = h.d; m_idx = h.i;
        end
        m_wr = pop;
        if (push) q.push_back({ioctl_addr[AW-1:0], ioctl_dout, ioctl_index});
        if (start) begin
            m_count = 0;
            m_ovf   = 0;
        end
        if (pop && m_count != 25'h1FF_FFFF) m_count = m_count + 1;
        if (drop) m_ovf = 1;
        m_wait  = (q.size() >= HW);
        m_phase = np;
        m_done  = (np == 3);
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {ioctl_wait, dn_wr, dn_busy, dn_done, overflow, dn_addr, dn_data, dn_index, dn_count};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_wait, m_wr, (m_phase != 0), m_done, m_ovf, m_addr, m_data, m_idx, m_count};
    endfunction

    // One clk_sys cycle: inputs applied between edges, model advanced at the edge.
    task automatic cyc(input logic c, input logic dl, input logic wr,
                       input logic [24:0] a, input logic [7:0] d, input logic [7:0] ix);
        ce = c; ioctl_download = dl; ioctl_wr = wr;
        ioctl_addr = a; ioctl_dout = d; ioctl_index = ix;
        @(posedge clk_sys);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 0; ce = 0; ioctl_download = 0; ioctl_wr = 0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        model_reset();
        @(posedge clk_sys); #1;
        if (obs_vec() !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h, expected 0", obs_vec());
        end
        n_vec++;
        reset_n = 1;
        cyc(0, 0, 0, '0, '0, '0);
        if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_idle: got %h, expected %h", obs_vec(), exp_vec());
        end
        n_vec++;
        $display("test_reset done");
    endtask

    task automatic test_basic_order();
        logic [24:0] ta [3];
        logic [7:0]  td [3];
        int pc[$];
        int got = 0;
        int dones = 0;
        ta[0] = 25'h00000; ta[1] = 25'h00001; ta[2] = 25'h1FFFF;
        td[0] = 8'hA5;     td[1] = 8'h5A;     td[2] = 8'hFF;
        for (int k = 0; k < 40; k++) begin
            cyc((k % 4) == 3, k < 3, k < 3, (k < 3) ? ta[k % 3] : 25'h0,
                (k < 3) ? td[k % 3] : 8'h0, 8'h00);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL basic_cycle%0d: got %h, expected %h", k, obs_vec(), exp_vec());
            end
            n_vec++;
            if (dn_wr) begin
                if (got < 3) begin
                    if (dn_addr !== ta[got][AW-1:0] || dn_data !== td[got]) begin
                        n_err++;
                        $display("FAIL basic_order%0d: got %h/%h, expected %h/%h",
                                 got, dn_addr, dn_data, ta[got][AW-1:0], td[got]);
                    end
                    n_vec++;
                end
                got++;
                pc.push_back(k);
            end
            if (dn_done) begin
                dones++;
                if (dn_count !== 25'd3) begin
                    n_err++; $display("FAIL basic_count: got %0d, expected 3", dn_count);
                end
                n_vec++;
            end
        end
        if (got != 3 || dones != 1) begin
            n_err++; $display("FAIL basic_pulses: got %0d wr/%0d done, expected 3/1", got, dones);
        end
        n_vec++;
        if (pc.size() == 3 && (pc[1] - pc[0] != 4 || pc[2] - pc[1] != 4)) begin
            n_err++; $display("FAIL basic_spacing: got %0d,%0d, expected 4,4", pc[1] - pc[0], pc[2] - pc[1]);
        end
        n_vec++;
        if (dn_busy !== 1'b0) begin
            n_err++; $display("FAIL basic_busy: got %b, expected 0", dn_busy);
        end
        n_vec++;
        $display("test_basic_order done: %0d writes", got);
    endtask

    task automatic test_back_pressure();
        int pulses = 0;
        int dones = 0;
        for (int k = 0; k < 9; k++) begin
            cyc(0, 1, 1, 25'($urandom), 8'($urandom), 8'($urandom));
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL bp_push%0d: got %h, expected %h", k, obs_vec(), exp_vec());
            end
            n_vec++;
            if (k == 4 || k == 5) begin
                if (ioctl_wait !== (k == 5)) begin
                    n_err++; $display("FAIL bp_wait_push%0d: got %b, expected %b", k + 1, ioctl_wait, k == 5);
                end
                n_vec++;
            end
            if (k == 7 || k == 8) begin
                if (overflow !== (k == 8)) begin
                    n_err++; $display("FAIL bp_overflow_push%0d: got %b, expected %b", k + 1, overflow, k == 8);
                end
                n_vec++;
            end
        end
        for (int k = 0; k < 30; k++) begin
            cyc(1, 0, 0, '0, '0, '0);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL bp_drain%0d: got %h, expected %h", k, obs_vec(), exp_vec());
            end
            n_vec++;
            if (dn_wr) pulses++;
            if (ioctl_wait !== ((8 - pulses) >= HW)) begin
                n_err++; $display("FAIL bp_wait_drain%0d: got %b, expected %b", k, ioctl_wait, (8 - pulses) >= HW);
            end
            n_vec++;
            if (dn_done) dones++;
        end
        if (pulses != 8 || dones != 1 || dn_count !== 25'd8 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL bp_summary: got %0d wr/%0d done/count %0d/ovf %b, expected 8/1/8/1",
                     pulses, dones, dn_count, overflow);
        end
        n_vec++;
        $display("test_back_pressure done: %0d writes", pulses);
    endtask

    task automatic test_addr_trunc();
        logic [AW-1:0] sb[$];
        logic [24:0]   a;
        int got = 0;
        for (int k = 0; k < 20; k++) begin
            a = (k == 0) ? 25'h123456 : 25'($urandom);
            if (k < 4) sb.push_back(a[AW-1:0]);
            cyc(1, k < 4, k < 4, a, 8'($urandom), 8'($urandom));
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL trunc_cycle%0d: got %h, expected %h", k, obs_vec(), exp_vec());
            end
            n_vec++;
            if (dn_wr) begin
                if (got == 0 && dn_addr !== 17'h03456) begin
                    n_err++; $display("FAIL trunc_first: got %h, expected 03456", dn_addr);
                end
                if (sb.size() > 0) begin
                    if (dn_addr !== sb[0]) begin
                        n_err++; $display("FAIL trunc_addr%0d: got %h, expected %h", got, dn_addr, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                n_vec++;
                got++;
            end
        end
        $display("test_addr_trunc done: %0d writes", got);
    endtask

    task automatic test_back_to_back();
        logic [7:0] sb[$];
        logic [7:0] d;
        int pulses = 0;
        int waits = 0;
        for (int k = 0; k < 40; k++) begin
            d = 8'($urandom);
            if (k < 20) sb.push_back(d);
            cyc(1, k < 20, k < 20, 25'(k), d, 8'h01);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL b2b_cycle%0d: got %h, expected %h", k, obs_vec(), exp_vec());
            end
            n_vec++;
            if (ioctl_wait) waits++;
            if (dn_wr) begin
                pulses++;
                if (sb.size() > 0) begin
                    if (dn_data !== sb[0]) begin
                        n_err++; $display("FAIL b2b_data%0d: got %h, expected %h", pulses, dn_data, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                n_vec++;
            end
        end
        if (pulses != 20 || waits != 0) begin
            n_err++; $display("FAIL b2b_summary: got %0d wr/%0d wait, expected 20/0", pulses, waits);
        end
        n_vec++;
        $display("test_back_to_back done: %0d writes", pulses);
    endtask

    task automatic test_merge();
        int pulses = 0;
        int dones = 0;
        logic c, dl, wr;
        for (int k = 0; k < 40; k++) begin
            c  = (k >= 7);
            dl = (k < 4) || (k == 5) || (k == 6);
            wr = dl;
            cyc(c, dl, wr, 25'(k), 8'($urandom), 8'h02);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL merge_cycle%0d: got %h, expected %h", k, obs_vec(), exp_vec());
            end
            n_vec++;
            if (dn_wr) pulses++;
            if (dn_done) begin
                dones++;
                if (pulses != 6 || dn_count !== 25'd6) begin
                    n_err++; $display("FAIL merge_done: got %0d wr/count %0d, expected 6/6", pulses, dn_count);
                end
                n_vec++;
            end
        end
        if (dones != 1) begin
            n_err++; $display("FAIL merge_dones: got %0d, expected 1", dones);
        end
        n_vec++;
        $display("test_merge done: %0d writes", pulses);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int dones = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 1, 25'($urandom), 8'($urandom), 8'h03);
        end
        #2;
        reset_n = 0;
        model_reset();
        #1;
        if (obs_vec() !== '0) begin
            n_err++; $display("FAIL rstmid_async: got %h, expected 0", obs_vec());
        end
        n_vec++;
        ce = 1; ioctl_download = 0; ioctl_wr = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1;
        for (int k = 0; k < 20; k++) begin
            cyc(1, k == 0, k == 0, 25'h00042, 8'h99, 8'h04);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL rstmid_cycle%0d: got %h, expected %h", k, obs_vec(), exp_vec());
            end
            n_vec++;
            if (dn_wr) pulses++;
            if (dn_done) dones++;
        end
        if (pulses != 1 || dones != 1 || dn_count !== 25'd1) begin
            n_err++; $display("FAIL rstmid_summary: got %0d wr/%0d done/count %0d, expected 1/1/1",
                              pulses, dones, dn_count);
        end
        n_vec++;
        $display("test_reset_mid done: %0d writes", pulses);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 460; k++) begin
            if (k < 400) begin
                cyc($urandom_range(0, 2) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 1) == 1,
                    25'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                cyc(1, 0, 0, '0, '0, '0);
            end
            if (obs_vec() !== exp_vec()) begin
                bad++; n_err++;
                $display("FAIL random_cycle%0d: got %h, expected %h", k, obs_vec(), exp_vec());
            end
            n_vec++;
        end
        if (dn_busy !== 1'b0) begin
            n_err++; $display("FAIL random_idle: got busy %b, expected 0", dn_busy);
        end
        n_vec++;
        $display("test_random done: %0d cycle miscompares", bad);
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_back_pressure();
        test_addr_trunc();
        test_back_to_back();
        test_merge();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
